// File: rtl/pipe_ctrl_pkg.sv
// Shared types and parameter helpers for the hazard/forwarding controller.
package pipe_ctrl_pkg;

    localparam int MAX_STAGES  = 8;
    localparam int MAX_ADDR_W  = 8;
    localparam int FWD_REGFILE = 0;

    typedef logic [3:0] fwd_sel_t;

    typedef struct packed {
        logic                  valid;
        logic [MAX_ADDR_W-1:0] rd;
        logic                  wb;
        logic                  mem;
    } tag_t;

    function automatic bit params_ok(int ns, int aw, int alu, int ld);
        return ns >= 2 && ns <= MAX_STAGES &&
               aw >= 1 && aw <= MAX_ADDR_W &&
               alu >= 2 && alu <= ns &&
               ld >= alu && ld <= ns;
    endfunction

    function automatic int sel_width(int ns);
        return $clog2(ns + 1);
    endfunction

endpackage

// File: rtl/pipeline_control_if.sv
// ID-side request and controller response bundle.
interface pipeline_control_if #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_STAGES = 3
);
    localparam int SEL_W = $clog2(NUM_STAGES + 1);

    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1_addr;
    logic [REG_ADDR_W-1:0] id_rs2_addr;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [REG_ADDR_W-1:0] id_rd_addr;
    logic                  id_wb_en;
    logic                  id_wb_from_mem;
    logic                  flush;
    logic                  pipe_hold;
    logic                  stall_id;
    logic [SEL_W-1:0]      fwd_rs1_sel_ex;
    logic [SEL_W-1:0]      fwd_rs2_sel_ex;
    logic [NUM_STAGES-1:0] stage_wb_en;
    logic [31:0]           stall_count;

    modport master (
        output id_valid, id_rs1_addr, id_rs2_addr,
        output id_use_rs1, id_use_rs2, id_rd_addr,
        output id_wb_en, id_wb_from_mem, flush, pipe_hold,
        input  stall_id, fwd_rs1_sel_ex, fwd_rs2_sel_ex,
        input  stage_wb_en, stall_count
    );

    modport slave (
        input  id_valid, id_rs1_addr, id_rs2_addr,
        input  id_use_rs1, id_use_rs2, id_rd_addr,
        input  id_wb_en, id_wb_from_mem, flush, pipe_hold,
        output stall_id, fwd_rs1_sel_ex, fwd_rs2_sel_ex,
        output stage_wb_en, stall_count
    );

endinterface

// File: rtl/pipe_ctrl_match.sv
// Youngest-producer search for one source register against the tag vector.
module pipe_ctrl_match
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_READY  = 2,
    parameter int LOAD_READY = 3,
    parameter int SEL_W      = 2
) (
    input  tag_t [NUM_STAGES-1:1] tags,
    input  logic [REG_ADDR_W-1:0] addr,
    input  logic                  use_src,
    output logic [SEL_W-1:0]      sel,
    output logic                  hazard
);

    logic hit;
    logic hit_mem;
    int   k;
    int   ready;

    always_comb begin
        hit     = 1'b0;
        hit_mem = 1'b0;
        k       = 0;
        ready   = ALU_READY;
        sel     = SEL_W'(FWD_REGFILE);
        hazard  = 1'b0;
        // Scan oldest to youngest so the youngest hit wins.
        for (int s = NUM_STAGES - 1; s >= 1; s--) begin
            if (tags[s].valid && tags[s].wb &&
                tags[s].rd == MAX_ADDR_W'(addr)) begin
                hit     = 1'b1;
                hit_mem = tags[s].mem;
                k       = s;
            end
        end
        if (hit && use_src) begin
            ready = hit_mem ? LOAD_READY : ALU_READY;
            if (k + 1 >= ready) begin
                sel = SEL_W'(k + 1);
            end else begin
                hazard = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipeline_control.sv
// Tag shift register, forwarding selects, load-use stall and stall counter.
module pipeline_control
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_READY  = 2,
    parameter int LOAD_READY = 3
) (
    input logic clk,
    input logic rst,
    pipeline_control_if.slave bus
);

    localparam int SEL_W = sel_width(NUM_STAGES);

    if (!params_ok(NUM_STAGES, REG_ADDR_W, ALU_READY, LOAD_READY)) begin : g_bad_params
        $error("pipeline_control: illegal parameter combination");
    end

    tag_t [NUM_STAGES-1:1] tags;
    logic                  last_wb;
    logic [SEL_W-1:0]      sel1_q;
    logic [SEL_W-1:0]      sel2_q;
    logic [SEL_W-1:0]      sel1_c;
    logic [SEL_W-1:0]      sel2_c;
    logic                  haz1;
    logic                  haz2;
    logic                  stall;
    logic                  enter;
    logic [31:0]           cnt;
    tag_t                  id_tag;

    pipe_ctrl_match #(
        .NUM_STAGES(NUM_STAGES), .REG_ADDR_W(REG_ADDR_W),
        .ALU_READY(ALU_READY), .LOAD_READY(LOAD_READY), .SEL_W(SEL_W)
    ) u_rs1 (
        .tags(tags), .addr(bus.id_rs1_addr), .use_src(bus.id_use_rs1),
        .sel(sel1_c), .hazard(haz1)
    );

    pipe_ctrl_match #(
        .NUM_STAGES(NUM_STAGES), .REG_ADDR_W(REG_ADDR_W),
        .ALU_READY(ALU_READY), .LOAD_READY(LOAD_READY), .SEL_W(SEL_W)
    ) u_rs2 (
        .tags(tags), .addr(bus.id_rs2_addr), .use_src(bus.id_use_rs2),
        .sel(sel2_c), .hazard(haz2)
    );

    assign stall = bus.id_valid && (haz1 || haz2) && !bus.flush && !bus.pipe_hold;
    assign enter = bus.id_valid && !stall && !bus.flush;

    always_comb begin
        id_tag = '0;
        if (enter) begin
            id_tag.valid = 1'b1;
            id_tag.rd    = MAX_ADDR_W'(bus.id_rd_addr);
            id_tag.wb    = bus.id_wb_en && (bus.id_rd_addr != '0);
            id_tag.mem   = bus.id_wb_from_mem;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tags    <= '0;
            last_wb <= 1'b0;
            sel1_q  <= '0;
            sel2_q  <= '0;
            cnt     <= '0;
        end else if (!bus.pipe_hold) begin
            tags[1] <= id_tag;
            for (int i = 2; i <= NUM_STAGES - 1; i++) begin
                tags[i] <= tags[i-1];
            end
            last_wb <= tags[NUM_STAGES-1].valid && tags[NUM_STAGES-1].wb;
            sel1_q  <= enter ? sel1_c : '0;
            sel2_q  <= enter ? sel2_c : '0;
            if (stall) begin
                cnt <= cnt + 32'd1;
            end
        end
    end

    always_comb begin
        bus.stage_wb_en = '0;
        for (int i = 1; i <= NUM_STAGES - 1; i++) begin
            bus.stage_wb_en[i-1] = tags[i].valid && tags[i].wb;
        end
        bus.stage_wb_en[NUM_STAGES-1] = last_wb;
    end

    assign bus.stall_id       = stall;
    assign bus.fwd_rs1_sel_ex = sel1_q;
    assign bus.fwd_rs2_sel_ex = sel2_q;
    assign bus.stall_count    = cnt;

endmodule

// File: tb/tb_pipeline_control.sv
// Vector-table bench for pipeline_control with default parameters.
module tb_pipeline_control;

    typedef struct {
        bit          r;
        bit          v;
        logic [4:0]  rs1;
        bit          u1;
        logic [4:0]  rs2;
        bit          u2;
        logic [4:0]  rd;
        bit          wb;
        bit          mem;
        bit          fl;
        bit          ho;
        bit          cs;
        bit          es;
        logic [1:0]  s1;
        logic [1:0]  s2;
        logic [2:0]  wbe;
        logic [31:0] cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    pipeline_control_if #(.REG_ADDR_W(5), .NUM_STAGES(3)) bus ();

    pipeline_control dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(bit r, bit v, int rs1, bit u1, int rs2, bit u2,
                                int rd, bit wb, bit mem, bit fl, bit ho,
                                bit cs, bit es, int s1, int s2, int wbe, int cnt);
        vec_t t;
        t.r = r; t.v = v; t.rs1 = 5'(rs1); t.u1 = u1;
        t.rs2 = 5'(rs2); t.u2 = u2; t.rd = 5'(rd);
        t.wb = wb; t.mem = mem; t.fl = fl; t.ho = ho;
        t.cs = cs; t.es = es; t.s1 = 2'(s1); t.s2 = 2'(s2);
        t.wbe = 3'(wbe); t.cnt = 32'(cnt);
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, want);
        end
    endtask

    task automatic apply(input vec_t t);
        vec_t e;
        @(negedge clk);
        rst                = t.r;
        bus.id_valid       = t.v;
        bus.id_rs1_addr    = t.rs1;
        bus.id_use_rs1     = t.u1;
        bus.id_rs2_addr    = t.rs2;
        bus.id_use_rs2     = t.u2;
        bus.id_rd_addr     = t.rd;
        bus.id_wb_en       = t.wb;
        bus.id_wb_from_mem = t.mem;
        bus.flush          = t.fl;
        bus.pipe_hold      = t.ho;
        #1;
        if (t.cs) chk("stall_id", 32'(bus.stall_id), 32'(t.es));
        exp_q.push_back(t);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("fwd_rs1_sel_ex", 32'(bus.fwd_rs1_sel_ex), 32'(e.s1));
            chk("fwd_rs2_sel_ex", 32'(bus.fwd_rs2_sel_ex), 32'(e.s2));
            chk("stage_wb_en", 32'(bus.stage_wb_en), 32'(e.wbe));
            chk("stall_count", bus.stall_count, e.cnt);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.id_valid = 0; bus.id_rs1_addr = 0; bus.id_rs2_addr = 0;
        bus.id_use_rs1 = 0; bus.id_use_rs2 = 0; bus.id_rd_addr = 0;
        bus.id_wb_en = 0; bus.id_wb_from_mem = 0;
        bus.flush = 0; bus.pipe_hold = 0;

        // r v rs1 u1 rs2 u2 rd wb mem fl ho | cs es s1 s2 wbe cnt
        tbl.push_back(mk(1,1, 5,1, 6,1, 7,1,1,0,0, 0,0, 0,0,0,0));
        tbl.push_back(mk(1,1, 7,1, 7,1, 7,1,0,1,1, 0,0, 0,0,0,0));
        tbl.push_back(mk(0,1, 1,1, 2,1, 5,1,0,0,0, 1,0, 0,0,1,0));
        tbl.push_back(mk(0,1, 5,1, 5,1, 6,1,0,0,0, 1,0, 2,2,3,0));
        tbl.push_back(mk(0,1, 5,1, 0,0, 7,1,1,0,0, 1,0, 3,0,7,0));
        tbl.push_back(mk(0,1, 7,1, 0,1, 8,1,0,0,0, 1,1, 0,0,6,1));
        tbl.push_back(mk(0,1, 7,1, 0,1, 8,1,0,0,0, 1,0, 3,0,5,1));
        tbl.push_back(mk(0,1, 1,1, 0,0, 0,1,0,0,0, 1,0, 0,0,2,1));
        tbl.push_back(mk(0,1, 0,1, 0,1, 9,1,0,0,0, 1,0, 0,0,5,1));
        tbl.push_back(mk(0,1, 2,1, 0,0,10,1,0,0,0, 1,0, 0,0,3,1));
        tbl.push_back(mk(0,0,10,1, 0,0, 0,0,0,0,0, 1,0, 0,0,6,1));
        tbl.push_back(mk(0,1, 3,1, 0,0, 0,0,0,0,0, 1,0, 0,0,4,1));
        tbl.push_back(mk(0,1,10,1,10,1,11,1,0,0,0, 1,0, 0,0,1,1));
        tbl.push_back(mk(0,1,11,1, 0,0,12,1,1,0,0, 1,0, 2,0,3,1));
        tbl.push_back(mk(0,1,12,1,12,1,13,1,0,1,0, 1,0, 0,0,6,1));
        tbl.push_back(mk(0,1,12,1,12,1,13,1,0,0,0, 1,0, 3,3,5,1));
        tbl.push_back(mk(0,1,13,1, 0,0,14,1,1,0,0, 1,0, 2,0,3,1));
        tbl.push_back(mk(0,1,14,1, 0,0,15,1,0,0,1, 1,0, 2,0,3,1));
        tbl.push_back(mk(0,1,14,1, 0,0,15,1,0,1,1, 1,0, 2,0,3,1));
        tbl.push_back(mk(0,1,14,1, 0,0,15,1,0,0,1, 1,0, 2,0,3,1));
        tbl.push_back(mk(0,1,14,1, 0,0,15,1,0,0,0, 1,1, 0,0,6,2));
        tbl.push_back(mk(0,1,14,1, 0,0,15,1,0,0,0, 1,0, 3,0,5,2));
        tbl.push_back(mk(1,1,16,1, 0,0,16,1,0,0,0, 0,0, 0,0,0,0));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,0,0,0, 1,0, 0,0,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // rs2 load-use with hold during the hazard, then youngest-match priority
        apply(mk(0,1, 0,0, 0,0,20,1,1,0,0, 1,0, 0,0,1,0));
        apply(mk(0,1, 0,1,20,1,21,1,0,0,1, 1,0, 0,0,1,0));
        apply(mk(0,1, 0,1,20,1,21,1,0,0,0, 1,1, 0,0,2,1));
        apply(mk(0,1, 0,1,20,1,21,1,0,0,0, 1,0, 0,3,5,1));
        apply(mk(0,1, 0,0, 0,0,21,1,0,0,0, 1,0, 0,0,3,1));
        apply(mk(0,1,21,1, 0,0,22,1,0,0,0, 1,0, 2,0,7,1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_control.md
# pipeline_control

Parametrised hazard, forwarding and flush controller for the pipelined RISC-V core. It sits beside the ID stage and keeps its own shift register of in-flight destination tags, one per post-ID stage. From those tags it computes operand-forwarding selects, load-use stalls and per-stage writeback enables, so the datapath no longer plumbs rd/writeback flags through every pipeline register for hazard purposes. It generalises the fixed three-deep forwarding logic in these ways:

- configurable depth and result-ready stages;
- an external whole-pipe hold;
- an always-correct register write enable;
- a stall performance counter.

## Interface
Parameters:
- NUM_STAGES, 3: post-ID stages tracked; stage 1 = EX, stage NUM_STAGES = WB; legal 2..8
- REG_ADDR_W, 5: register address width
- ALU_READY, 2: first stage whose output bus carries an ALU result; legal 2..NUM_STAGES
- LOAD_READY, 3: first stage whose output bus carries load data; legal ALU_READY..NUM_STAGES

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs1_addr, id_rs2_addr  in  REG_ADDR_W  source registers
- id_use_rs1, id_use_rs2  in  1  source actually read
- id_rd_addr  in  REG_ADDR_W  destination
- id_wb_en  in  1  instruction writes rd
- id_wb_from_mem  in  1  rd comes from a load
- flush  in  1  taken jump resolved in EX this cycle
- pipe_hold  in  1  freeze all stages (e.g. multi-cycle memory)
- stall_id  out  1  hold PC and IF/ID, inject bubble into EX
- fwd_rs1_sel_ex, fwd_rs2_sel_ex  out  SEL_W=$clog2(NUM_STAGES+1)  EX operand source: 0 = ID/EX register value, s = output bus of stage s
- stage_wb_en  out  NUM_STAGES  valid && wb_en && rd!=0 per stage; bit NUM_STAGES-1 drives the register-file write enable
- stall_count  out  32  hazard-stall cycles

## Operation
- Tag entry per stage: valid, rd, wb (wb_en && rd!=0), mem. An instruction writing x0 never matches.
- Match for rsN at ID: the youngest valid stage k in 1..NUM_STAGES-1 with wb && rd==rsN && use_rsN. Stage NUM_STAGES never matches: the register file is write-through, so the ID read already sees that value.
- Ready stage R = LOAD_READY if mem, else ALU_READY.
- If k+1 >= R: forward; the select registered for EX is k+1.
- If k+1 < R: hazard stall.
- stall_id = id_valid && hazard && !flush && !pipe_hold.
- Advance (pipe_hold=0): stage i+1 <= stage i. Stage 1 <= ID tag, with valid = id_valid && !stall_id && !flush; otherwise a bubble. Selects load 0 on a bubble, else the computed values.
- pipe_hold=1: every entry and select holds; flush is ignored that cycle (EX is frozen, so flush re-asserts); stall_id=0; stall_count holds.
- Priority: rst > pipe_hold > flush > hazard.
- stall_count += 1 on each cycle stall_id=1; wraps at 2^32.

## Timing
- stall_id and the match logic are combinational from the ID inputs and the current entries.
- fwd selects and entries are registered: one cycle after ID.
- Reset (next edge after rst=1): all entries invalid, stage_wb_en=0, fwd_*_sel_ex=0, stall_count=0; stall_id=0 while entries are invalid.
- rst asserted mid-operation discards in-flight tags on that edge; no write enable is produced for them.
- Load-use with defaults: load directly ahead gives 1 stall cycle, then forwards from stage 3. Load two ahead forwards with no stall.
- The load stall length is generally max(0, R-k-1) cycles, re-evaluated each cycle as the bubble advances.
- flush on the same cycle as a hazard: ID is killed, no stall, stall_count unchanged.

## Structure
- pipe_ctrl_pkg holds:
  - tag_t struct {valid, rd, wb, mem};
  - fwd_sel_t;
  - FWD_REGFILE=0;
  - parameter legality checks as functions/asserts.
- Sub-module pipe_ctrl_match: one source address against the entry vector. It returns the youngest-match stage and the hazard flag, and is instantiated twice (rs1, rs2).
- Top holds the tag shift register, the select registers and the counter.

## Test plan
All scenarios use default parameters.
- Reset: assert rst for 2 cycles with garbage inputs -> all outputs 0, stage_wb_en=3'b000.
- ALU back-to-back: add x5 then add x6,x5,x5 -> no stall; fwd_rs1_sel_ex=fwd_rs2_sel_ex=2 for the second instruction.
- Load-use: lw x7 then add x8,x7,x0 -> stall_id=1 for exactly 1 cycle, then fwd_rs1_sel_ex=3, stall_count=1.
- x0 and WB distance:
  - writer of x0 followed by a reader of x0 -> sel 0, no stall;
  - writer three ahead of the reader -> sel 0 (register file), stage_wb_en[2]=1 on the writer's WB cycle.
- Flush plus hold:
  - flush during a load-use hazard -> stall_id=0 and a bubble enters EX;
  - pipe_hold=1 for 3 cycles mid-stream -> entries, selects and stall_count unchanged, then resume exactly.
